// File: rtl/cic_decim_ctrl_if.sv
// Control/status bundle between a CIC decimator controller and its surroundings.
// CIC_DECIM_CTRL_STATS_EN adds the decimation/drop statistics counters.
interface cic_decim_ctrl_if #(
   parameter int unsigned RW = 8
);
   logic          i_enable;
   logic          i_ready;
   logic          i_cfg_wr;
   logic [RW-1:0] i_rate;
   logic          o_int_ready;
   logic          o_comb_ready;
   logic          o_flush;
   logic          o_cfg_err;
   logic          o_running;
   logic [RW-1:0] o_rate;
`ifdef CIC_DECIM_CTRL_STATS_EN
   logic [15:0]   o_dec_count;
   logic [15:0]   o_drop_count;
`endif

   modport master (
`ifdef CIC_DECIM_CTRL_STATS_EN
      input  o_dec_count, o_drop_count,
`endif
      output i_enable, i_ready, i_cfg_wr, i_rate,
      input  o_int_ready, o_comb_ready, o_flush, o_cfg_err, o_running, o_rate
   );

   modport slave (
`ifdef CIC_DECIM_CTRL_STATS_EN
      output o_dec_count, o_drop_count,
`endif
      input  i_enable, i_ready, i_cfg_wr, i_rate,
      output o_int_ready, o_comb_ready, o_flush, o_cfg_err, o_running, o_rate
   );
endinterface

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: gates samples, counts to the rate, aligns decimation ticks, suppresses warm-up.
// Optional statistics counters are enabled with CIC_DECIM_CTRL_STATS_EN.
module cic_decim_ctrl #(
   parameter int unsigned N            = 3,
   parameter int unsigned RW           = 8,
   parameter int unsigned DEFAULT_RATE = 8
) (
   input logic             i_clk,
   input logic             i_reset,
   cic_decim_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;
   localparam int unsigned WW = $clog2(N + 1);

   state_t        state, state_d;
   logic [RW-1:0] rate_q, cnt_q;
   logic [WW-1:0] wu_q;
   logic [N-1:0]  sr_q, sr_shift, sr_d;
   logic          cfg_ok, accept, tick, dly, flush_q, err_q;

   assign cfg_ok   = bus.i_cfg_wr && (bus.i_rate >= RW'(2));
   assign tick     = accept && (cnt_q == rate_q - RW'(1));
   // Top stage of the shift register is the o_comb_ready flop; dly is the tick about to enter it.
   assign sr_shift = (sr_q << 1) | N'(tick);
   assign dly      = sr_shift[N-1];

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (cfg_ok)
         state_d = bus.i_enable ? WARMUP : IDLE;
      else if (!bus.i_enable)
         state_d = IDLE;
      else begin
         case (state)
            IDLE:    state_d = WARMUP;
            WARMUP:  if (dly && wu_q == WW'(N - 1)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   // A valid rate write takes the sample slot; a rejected write leaves the sample stream untouched.
   always_comb begin
      accept        = 1'b0;
      bus.o_running = 1'b0;
      if (state != IDLE) accept = bus.i_ready && !cfg_ok;
      if (state == RUN)  bus.o_running = 1'b1;
   end

   always_comb begin
      sr_d      = sr_shift;
      sr_d[N-1] = sr_shift[N-1] && (state == RUN) && bus.i_enable;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rate_q  <= RW'(DEFAULT_RATE);
         cnt_q   <= '0;
         wu_q    <= '0;
         sr_q    <= '0;
         flush_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= bus.i_cfg_wr && !cfg_ok;
         if (cfg_ok) begin
            rate_q  <= bus.i_rate;
            cnt_q   <= '0;
            wu_q    <= '0;
            sr_q    <= '0;
            flush_q <= 1'b1;
         end else begin
            flush_q <= (state == IDLE) && bus.i_enable;
            sr_q    <= sr_d;
            if (accept) cnt_q <= tick ? '0 : cnt_q + RW'(1);
            if (state == IDLE)
               wu_q <= '0;
            else if (state == WARMUP && bus.i_enable && dly)
               wu_q <= wu_q + WW'(1);
         end
      end
   end

   assign bus.o_int_ready  = accept;
   assign bus.o_comb_ready = sr_q[N-1];
   assign bus.o_flush      = flush_q;
   assign bus.o_cfg_err    = err_q;
   assign bus.o_rate       = rate_q;

`ifdef CIC_DECIM_CTRL_STATS_EN
   logic [15:0] dec_q, drop_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         dec_q  <= '0;
         drop_q <= '0;
      end else begin
         if (sr_q[N-1])               dec_q  <= dec_q + 16'd1;
         if (bus.i_ready && !accept) drop_q <= drop_q + 16'd1;
      end
   end

   assign bus.o_dec_count  = dec_q;
   assign bus.o_drop_count = drop_q;
`endif
endmodule
